// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - state encoding and requester IDs shared by the data memory arbiter
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD0 = 3'd1,
    ST_CMD1 = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - requester selection; DMEM_ARB_RR_EN selects round-robin, else B has fixed priority
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last_grant,
  output req_id_t grant,
  output logic    valid
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    valid = req_a | req_b;
    grant = req_b ? REQ_B : REQ_A;
    // on a tie the side that did not win last time goes next
    if (req_a && req_b) begin
      grant = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    valid = req_a | req_b;
    grant = req_b ? REQ_B : REQ_A;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter (pipeline MEM stage A, stack unit B with two-word access)
// Optional round-robin tie break via DMEM_ARB_RR_EN; default build gives B fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORD_LENGTH   = 16,
  parameter int ADDRESS_SPACE = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_req,
  input  logic                       a_rw,
  input  logic [ADDRESS_SPACE-1:0]   a_addr,
  input  logic [WORD_LENGTH-1:0]     a_wdata,
  input  logic                       b_req,
  input  logic                       b_rw,
  input  logic                       b_dbl,
  input  logic [ADDRESS_SPACE-1:0]   b_addr,
  input  logic [2*WORD_LENGTH-1:0]   b_wdata,
  output logic                       gnt_a,
  output logic                       gnt_b,
  output logic                       done_a,
  output logic                       done_b,
  output logic [2*WORD_LENGTH-1:0]   rdata,
  output logic                       mem_en,
  output logic                       mem_rw,
  output logic [ADDRESS_SPACE-1:0]   mem_addr,
  output logic [WORD_LENGTH-1:0]     mem_wdata,
  input  logic [WORD_LENGTH-1:0]     mem_rdata,
  output logic                       busy
);

  localparam int W  = WORD_LENGTH;
  localparam int AW = ADDRESS_SPACE;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic            rw_q;
  logic            dbl_q;
  logic [AW-1:0]   addr_q;
  logic [2*W-1:0]  wdata_q;
  req_id_t         id_q;
  req_id_t         last_grant_q;
  req_id_t         pick_id;
  logic            pick_valid;
  logic            accept;

  dmem_arb_pick u_pick (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant_q),
    .grant      (pick_id),
    .valid      (pick_valid)
  );

  // requests are only looked at while idle
  assign accept = (state == ST_IDLE) && pick_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (pick_valid) state_nxt = ST_CMD0;
      end
      ST_CMD0: begin
        mem_en    = 1'b1;
        mem_rw    = rw_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q[W-1:0];
        state_nxt = dbl_q ? ST_CMD1 : ST_CAPT;
      end
      ST_CMD1: begin
        // upper word sits at the next address, wrapping at the top of memory
        mem_en    = 1'b1;
        mem_rw    = rw_q;
        mem_addr  = addr_q + ADDR_ONE;
        mem_wdata = wdata_q[2*W-1:W];
        state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q         <= 1'b0;
      dbl_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      id_q         <= REQ_A;
      last_grant_q <= REQ_A;
    end else if (accept) begin
      id_q         <= pick_id;
      last_grant_q <= pick_id;
      if (pick_id == REQ_B) begin
        rw_q    <= b_rw;
        dbl_q   <= b_dbl;
        addr_q  <= b_addr;
        wdata_q <= b_wdata;
      end else begin
        rw_q    <= a_rw;
        dbl_q   <= 1'b0;
        addr_q  <= a_addr;
        wdata_q <= {{W{1'b0}}, a_wdata};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      gnt_a  <= accept && (pick_id == REQ_A);
      gnt_b  <= accept && (pick_id == REQ_B);
      done_a <= (state == ST_DONE) && (id_q == REQ_A);
      done_b <= (state == ST_DONE) && (id_q == REQ_B);
    end
  end

  // memory read data is valid the cycle after each read command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rw_q) begin
      case (state)
        ST_CMD1: rdata[W-1:0] <= mem_rdata;
        ST_CAPT: begin
          if (dbl_q) rdata[2*W-1:W] <= mem_rdata;
          else       rdata <= {{W{1'b0}}, mem_rdata};
        end
        default: ;
      endcase
    end
  end

endmodule
